// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: hands the pin bus to init, refresh, write or read.
// Fixed priority refresh > write > read, one NOP cycle between bursts.
module sdram_arbit #(
    parameter logic [3:0] NOP = 4'b0111
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        flag_init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic        ref_req,
    input  logic        flag_ref_end,
    input  logic [3:0]  ref_cmd,
    input  logic [11:0] ref_addr,
    input  logic [1:0]  ref_bank,
    input  logic        wr_req,
    input  logic        flag_wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic        rd_req,
    input  logic        flag_rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    input  logic [1:0]  rd_bank,
    output logic        ref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [3:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic [1:0]  sdram_bank,
    output logic [2:0]  arb_state
);

    localparam logic [2:0] INIT  = 3'd0;
    localparam logic [2:0] ARBIT = 3'd1;
    localparam logic [2:0] AREF  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] READ  = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       ref_go;
    logic       wr_go;
    logic       rd_go;

    // grants are only decided while idling in ARBIT
    always_comb begin
        ref_go = (state == ARBIT) && ref_req;
        wr_go  = (state == ARBIT) && !ref_req && wr_req;
        rd_go  = (state == ARBIT) && !ref_req && !wr_req && rd_req;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: begin
                if (flag_init_end) state_nxt = ARBIT;
            end
            ARBIT: begin
                if (ref_go)     state_nxt = AREF;
                else if (wr_go) state_nxt = WRITE;
                else if (rd_go) state_nxt = READ;
            end
            AREF: begin
                if (flag_ref_end) state_nxt = ARBIT;
            end
            WRITE: begin
                if (flag_wr_end) state_nxt = ARBIT;
            end
            READ: begin
                if (flag_rd_end) state_nxt = ARBIT;
            end
            default: state_nxt = ARBIT;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state  <= INIT;
            ref_en <= 1'b0;
            wr_en  <= 1'b0;
            rd_en  <= 1'b0;
        end else begin
            state  <= state_nxt;
            ref_en <= ref_go;
            wr_en  <= wr_go;
            rd_en  <= rd_go;
        end
    end

    always_comb begin
        sdram_cmd  = NOP;
        sdram_addr = 12'd0;
        sdram_bank = 2'b00;
        case (state)
            INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
                sdram_bank = ref_bank;
            end
            WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: ;
        endcase
    end

    assign arb_state = state;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios with literal expectations,
// then random traffic compared every cycle against an owner-based model.
module tb_sdram_arbit;

    logic        sclk;
    logic        s_rst_n;
    logic        flag_init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        ref_req, flag_ref_end;
    logic [3:0]  ref_cmd;
    logic [11:0] ref_addr;
    logic [1:0]  ref_bank;
    logic        wr_req, flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_bank;
    logic        rd_req, flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        ref_en, wr_en, rd_en;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;
    logic [2:0]  arb_state;

    int checks = 0;
    int errors = 0;
    bit run = 1'b1;

    sdram_arbit dut (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .flag_init_end(flag_init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .flag_ref_end(flag_ref_end),
        .ref_cmd(ref_cmd), .ref_addr(ref_addr), .ref_bank(ref_bank),
        .wr_req(wr_req), .flag_wr_end(flag_wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .rd_req(rd_req), .flag_rd_end(flag_rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
        .sdram_bank(sdram_bank), .arb_state(arb_state)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (0 init, 1 idle, 2 ref, 3 wr, 4 rd)
    // and which grant bit {ref,wr,rd} was issued at the last edge.
    int         m_own = 0;
    logic [2:0] m_en = 3'b000;
    logic [2:0] m_req;
    logic [2:0] m_done;

    always @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            m_own = 0;
            m_en  = 3'b000;
        end else begin
            m_en   = 3'b000;
            m_req  = {ref_req, wr_req, rd_req};
            m_done = {flag_ref_end, flag_wr_end, flag_rd_end};
            if (m_own == 0) begin
                if (flag_init_end) m_own = 1;
            end else if (m_own == 1) begin
                for (int i = 2; i >= 0; i--) begin
                    if (m_req[i]) begin
                        m_own   = 4 - i;
                        m_en[i] = 1'b1;
                        break;
                    end
                end
            end else if (m_done[4 - m_own]) begin
                m_own = 1;
            end
        end
    end

    logic [2:0] prev_en = 3'b000;
    logic [3:0] e_cmd;
    logic [11:0] e_addr;
    logic [1:0] e_bank;

    always @(negedge sclk) begin
        if (run) begin
            case (m_own)
                0: begin
                    e_cmd = init_cmd; e_addr = init_addr; e_bank = 2'b00;
                end
                2: begin
                    e_cmd = ref_cmd; e_addr = ref_addr; e_bank = ref_bank;
                end
                3: begin
                    e_cmd = wr_cmd; e_addr = wr_addr; e_bank = wr_bank;
                end
                4: begin
                    e_cmd = rd_cmd; e_addr = rd_addr; e_bank = rd_bank;
                end
                default: begin
                    e_cmd = 4'b0111; e_addr = 12'd0; e_bank = 2'b00;
                end
            endcase
            chk("state", int'(arb_state), m_own);
            chk("en", int'({ref_en, wr_en, rd_en}), int'(m_en));
            chk("cmd", int'(sdram_cmd), int'(e_cmd));
            chk("addr", int'(sdram_addr), int'(e_addr));
            chk("bank", int'(sdram_bank), int'(e_bank));
            chk("onehot", int'($countones({ref_en, wr_en, rd_en}) <= 1), 1);
            chk("pulse", int'(prev_en & {ref_en, wr_en, rd_en}), 0);
            prev_en = {ref_en, wr_en, rd_en};
        end
    end

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic lit(input string name, input int st, input int en);
        chk({name, "_st"}, int'(arb_state), st);
        chk({name, "_en"}, int'({ref_en, wr_en, rd_en}), en);
    endtask

    initial begin
        s_rst_n = 1'b0;
        flag_init_end = 0;
        init_cmd = 4'b0010; init_addr = 12'h400;
        ref_req = 0; flag_ref_end = 0;
        ref_cmd = 4'b0001; ref_addr = 12'h011; ref_bank = 2'b01;
        wr_req = 0; flag_wr_end = 0;
        wr_cmd = 4'b0100; wr_addr = 12'h0a5; wr_bank = 2'b10;
        rd_req = 0; flag_rd_end = 0;
        rd_cmd = 4'b0101; rd_addr = 12'h35a; rd_bank = 2'b11;

        // reset and init exit
        repeat (3) tick;
        lit("rst", 0, 0);
        chk("rst_cmd", int'(sdram_cmd), 4'b0010);
        chk("rst_addr", int'(sdram_addr), 12'h400);
        chk("rst_bank", int'(sdram_bank), 0);
        s_rst_n = 1'b1;
        ref_req = 1;
        repeat (5) tick;
        lit("init_hold", 0, 0);
        chk("init_cmd", int'(sdram_cmd), 4'b0010);
        ref_req = 0;
        flag_init_end = 1;
        tick;
        flag_init_end = 0;
        lit("init_exit", 1, 0);
        chk("arbit_cmd", int'(sdram_cmd), 4'b0111);
        chk("arbit_addr", int'(sdram_addr), 0);

        // all three requests together
        ref_req = 1; wr_req = 1; rd_req = 1;
        tick;
        lit("pri_ref", 2, 3'b100);
        chk("ref_cmd", int'(sdram_cmd), 4'b0001);
        chk("ref_bank", int'(sdram_bank), 2'b01);
        ref_req = 0;
        tick;
        lit("ref_drop", 2, 0);
        flag_ref_end = 1;
        tick;
        flag_ref_end = 0;
        lit("gap1", 1, 0);
        chk("gap1_cmd", int'(sdram_cmd), 4'b0111);
        tick;
        lit("pri_wr", 3, 3'b010);
        wr_req = 0;
        repeat (3) tick;
        lit("wr_hold", 3, 0);
        flag_wr_end = 1;
        tick;
        flag_wr_end = 0;
        lit("gap2", 1, 0);
        tick;
        lit("pri_rd", 4, 3'b001);
        rd_req = 0;

        // foreign done flags ignored in READ
        flag_wr_end = 1; flag_ref_end = 1;
        tick;
        flag_wr_end = 0; flag_ref_end = 0;
        lit("rd_ignore", 4, 0);
        flag_rd_end = 1;
        tick;
        flag_rd_end = 0;
        lit("rd_end", 1, 0);

        // refresh arriving during a write waits
        wr_req = 1;
        tick;
        lit("wr2", 3, 3'b010);
        wr_req = 0; ref_req = 1;
        repeat (3) tick;
        lit("wr2_hold", 3, 0);
        chk("wr2_cmd", int'(sdram_cmd), 4'b0100);
        chk("wr2_bank", int'(sdram_bank), 2'b10);
        flag_wr_end = 1;
        tick;
        flag_wr_end = 0;
        lit("gap3", 1, 0);
        tick;
        lit("ref2", 2, 3'b100);

        // async reset while ref_en is high
        #2 s_rst_n = 1'b0;
        #1;
        lit("async_rst", 0, 0);
        tick;
        s_rst_n = 1'b1;
        repeat (4) tick;
        lit("post_rst", 0, 0);
        flag_init_end = 1;
        tick;
        flag_init_end = 0;
        lit("reinit", 1, 0);
        tick;
        lit("ref3", 2, 3'b100);
        ref_req = 0; flag_ref_end = 1;
        tick;
        flag_ref_end = 0;
        lit("ref3_end", 1, 0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            tick;
            s_rst_n = ($urandom_range(0, 249) != 0);
            flag_init_end = ($urandom_range(0, 3) == 0);
            ref_req = ($urandom_range(0, 5) == 0);
            wr_req = ($urandom_range(0, 2) == 0);
            rd_req = ($urandom_range(0, 2) == 0);
            flag_ref_end = ($urandom_range(0, 4) == 0);
            flag_wr_end = ($urandom_range(0, 4) == 0);
            flag_rd_end = ($urandom_range(0, 4) == 0);
            init_cmd = 4'($urandom); init_addr = 12'($urandom);
            ref_cmd = 4'($urandom); ref_addr = 12'($urandom);
            ref_bank = 2'($urandom);
            wr_cmd = 4'($urandom); wr_addr = 12'($urandom);
            wr_bank = 2'($urandom);
            rd_cmd = 4'($urandom); rd_addr = 12'($urandom);
            rd_bank = 2'($urandom);
        end
        s_rst_n = 1'b1;
        repeat (2) tick;
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
